debounce_rr_scheduler: RTL and testbench
========================================

// Module: debounce_rr_scheduler
// PURPOSE
//  Debounces CH switch inputs using one shared N-bit dwell timer instead of one counter per switch.
//  A round-robin arbiter grants the timer to one channel at a time whose synchronized input differs from its debounced level.
//  The block sits between raw board switches/buttons and the user logic.
//  Outputs per channel: a stable level plus a one-cycle tick on each committed edge.
// PARAMETERS
//  CH  4   number of switch channels (2..16)
//  N   21  timer width; dwell = 2^N-1 clk cycles (~42 ms at 50 MHz)
// PORTS
//  clk       in   1        system clock, all logic on rising edge
//  reset     in   1        synchronous, active-high reset
//  sw        in   CH       raw asynchronous switch inputs
//  db_level  out  CH       debounced level per channel (registered)
//  db_tick   out  CH       one-cycle pulse on a committed 0->1 or 1->0 change (registered)
//  busy      out  1        1 while the timer is granted to a channel (registered)
//  grant_id  out  clog2(CH) channel that currently holds the timer (registered)
// BEHAVIOUR
//  Reset (sync, active-high)
//   - At a clk edge with reset=1: db_level=0, db_tick=0, busy=0, grant_id=0.
//   - Also cleared: timer=0, rr_ptr=0, state=IDLE, sync flops=0.
//   - Reset overrides any in-flight dwell; no tick is generated.
//  Synchronizer
//   - 2-FF synchronizer per bit; s=sync output.
//   - req[i] = s[i] ^ db_level[i], combinational.
//  FSM states
//   - IDLE
//     - If req!=0: grant the first i with req[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod CH.
//     - On grant: grant_id<=i, timer<=2^N-1, busy<=1, go to RUN.
//     - If req=0: stay in IDLE.
//   - RUN (g = grant_id)
//     - Abort: if s[g]==db_level[g] (bounce back), go to IDLE. busy<=0, rr_ptr<=g+1 mod CH, no tick, db_level unchanged.
//     - Otherwise timer_next = timer-1.
//     - Commit: if timer_next==0, then db_level[g]<=~db_level[g], db_tick[g]<=1, busy<=0, rr_ptr<=g+1 mod CH, go to IDLE.
//   - Illegal state: go to IDLE.
//  Latency and counting
//   - sw[i] change captured at edge k.
//   - Grant at edge k+2.
//   - Commit at edge k+2+(2^N-1), if the input is held stable.
//   - Earliest next grant is one cycle after a commit or abort; IDLE always lasts >=1 cycle.
//  Ticks and grants
//   - db_tick is 0 every cycle except the commit cycle. At most one bit is set per cycle.
//   - grant_id holds its last value while busy=0.
//  Contention
//   - Channels requesting during RUN wait; their req is re-evaluated in IDLE.
//   - A channel whose input returns to db_level while waiting is never granted and never ticks.
//  Width rules
//   - Timer never underflows; commit fires on the 1->0 decrement.
//   - rr_ptr wraps CH-1 -> 0.
// TESTING (CH=4, N=4, dwell 15 cycles)
//  1. Hold sw=0001 from edge 0.
//     -> grant_id=0 and busy=1 at edge 2.
//     -> db_level=0001 and db_tick=0001 at edge 17 only.
//     -> busy=0 at edge 17.
//  2. Toggle sw[0] every 5 cycles (bounce).
//     -> repeated aborts; db_level stays 0000 and db_tick stays 0000.
//     -> Then hold sw[0]=1: commit 15 cycles after the last grant.
//  3. sw=1111 at edge 0.
//     -> commits happen in order ch0, ch1, ch2, ch3.
//     -> Commits are 16 cycles apart; each db_tick bit fires once; final db_level=1111.
//  4. db_level=1111; rr_ptr=1 after the ch0 commit.
//     -> Drop sw[0] and sw[2] together: ch2 is granted before ch0.
//     -> Both end at 0 with one tick each.
//  5. Assert reset mid-RUN with timer=7.
//     -> Next edge: busy=0, db_level=0000, db_tick=0000, grant_id=0.
//     -> A re-dwell starts 2 cycles after reset is released if sw is still high.
//  6. Pulse sw[3] high for 3 cycles while ch1 holds the timer.
//     -> ch3 is never granted and db_tick[3] is never asserted.

Source files
------------

// File: rtl/debounce_rr_scheduler.sv
// rtl/debounce_rr_scheduler.sv - switch debouncer sharing one dwell timer across channels
// A round-robin arbiter hands the timer to one channel whose synchronized input disagrees with its level.
`timescale 1ns/1ps

module debounce_rr_scheduler #(
  parameter int CH = 4,
  parameter int N  = 21,
  localparam int GW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db_level,
  output logic [CH-1:0] db_tick,
  output logic          busy,
  output logic [GW-1:0] grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;

  state_t        state;
  logic [CH-1:0] sync_a;
  logic [CH-1:0] sync_b;
  logic [CH-1:0] req;
  logic [N-1:0]  timer;
  logic [N-1:0]  timer_next;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] ptr_after;
  logic [GW-1:0] pick;
  logic [GW:0]   cand;
  logic          found;

  assign req        = sync_b ^ db_level;
  assign timer_next = timer - N'(1);
  assign ptr_after  = (grant_id == GW'(CH - 1)) ? '0 : grant_id + GW'(1);

  // Walk offsets from the far end so the channel closest to rr_ptr wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (GW + 1)'(k);
      if (cand >= (GW + 1)'(CH)) begin
        cand = cand - (GW + 1)'(CH);
      end
      if (req[cand[GW-1:0]]) begin
        found = 1'b1;
        pick  = cand[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sync_a   <= '0;
      sync_b   <= '0;
      db_level <= '0;
      db_tick  <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      timer    <= '0;
      rr_ptr   <= '0;
    end else begin
      sync_a  <= sw;
      sync_b  <= sync_a;
      db_tick <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= pick;
            timer    <= '1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (sync_b[grant_id] == db_level[grant_id]) begin
            // Input bounced back before the dwell expired: drop the grant silently.
            busy   <= 1'b0;
            rr_ptr <= ptr_after;
            state  <= IDLE;
          end else if (timer_next == '0) begin
            db_level[grant_id] <= ~db_level[grant_id];
            db_tick[grant_id]  <= 1'b1;
            timer              <= timer_next;
            busy               <= 1'b0;
            rr_ptr             <= ptr_after;
            state              <= IDLE;
          end else begin
            timer <= timer_next;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_rr_scheduler.sv
// tb/tb_debounce_rr_scheduler.sv - directed bench for debounce_rr_scheduler with CH=4, N=4
`timescale 1ns/1ps

module tb_debounce_rr_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] sw;
  logic [3:0] db_level;
  logic [3:0] db_tick;
  logic       busy;
  logic [1:0] grant_id;

  int n_chk;
  int n_pass;
  int cyc;
  int tick_cnt [4];
  int tick_cyc [4];
  int grant_cnt;
  int g3_cnt;
  int multi_cnt;
  logic busy_q;

  int t0;
  int t1;
  int base [4];
  int gbase;
  int g3base;

  debounce_rr_scheduler #(.CH(4), .N(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db_level (db_level),
    .db_tick  (db_tick),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 4; i++) begin
      tick_cnt[i] = 0;
      tick_cyc[i] = -1;
    end
    grant_cnt = 0;
    g3_cnt    = 0;
    multi_cnt = 0;
    busy_q    = 1'b0;
  end

  // Event recorder, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (db_tick[i]) begin
        tick_cnt[i] = tick_cnt[i] + 1;
        tick_cyc[i] = cyc;
      end
    end
    if ($countones(db_tick) > 1) multi_cnt = multi_cnt + 1;
    if (busy && !busy_q) grant_cnt = grant_cnt + 1;
    if (busy && grant_id == 2'd3) g3_cnt = g3_cnt + 1;
    busy_q = busy;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sw    = 4'b0000;
    wait_edges(2);
  endtask

  task automatic snap();
    for (int i = 0; i < 4; i++) base[i] = tick_cnt[i];
    gbase  = grant_cnt;
    g3base = g3_cnt;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    sw     = 4'b1111;
    wait_edges(3);
    check("rst_level", int'(db_level), 0);
    check("rst_tick", int'(db_tick), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_grant", int'(grant_id), 0);

    // 1: single channel dwell
    do_reset();
    snap();
    reset = 1'b0;
    sw    = 4'b0001;
    t0    = cyc;
    wait_edges(2);
    check("t1_busy_e1", int'(busy), 0);
    wait_edges(1);
    check("t1_busy_e2", int'(busy), 1);
    check("t1_grant_e2", int'(grant_id), 0);
    wait_edges(14);
    check("t1_level_e16", int'(db_level), 0);
    check("t1_tick_e16", int'(db_tick), 0);
    wait_edges(1);
    check("t1_level_e17", int'(db_level), 1);
    check("t1_tick_e17", int'(db_tick), 1);
    check("t1_busy_e17", int'(busy), 0);
    wait_edges(1);
    check("t1_tick_e18", int'(db_tick), 0);
    check("t1_tick_cyc", tick_cyc[0], t0 + 18);
    check("t1_tick_cnt", tick_cnt[0] - base[0], 1);

    // 2: bouncing input aborts, then a steady level commits
    do_reset();
    snap();
    reset = 1'b0;
    for (int p = 0; p < 3; p++) begin
      sw = 4'b0001;
      wait_edges(5);
      sw = 4'b0000;
      wait_edges(5);
    end
    check("t2_bounce_level", int'(db_level), 0);
    check("t2_bounce_ticks", tick_cnt[0] - base[0], 0);
    check("t2_bounce_grants", grant_cnt - gbase, 3);
    sw = 4'b0001;
    t0 = cyc;
    wait_edges(20);
    check("t2_hold_cyc", tick_cyc[0], t0 + 18);
    check("t2_hold_ticks", tick_cnt[0] - base[0], 1);
    check("t2_hold_level", int'(db_level), 1);
    check("t2_hold_grants", grant_cnt - gbase, 4);

    // 3: all channels at once, served in order 16 cycles apart
    do_reset();
    snap();
    reset = 1'b0;
    sw    = 4'b1111;
    t0    = cyc;
    wait_edges(70);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_cyc_ch%0d", i), tick_cyc[i], t0 + 18 + 16 * i);
      check($sformatf("t3_cnt_ch%0d", i), tick_cnt[i] - base[i], 1);
    end
    check("t3_level", int'(db_level), 15);

    // 4: leave rr_ptr at 1 via two ch0 commits, then drop ch0 and ch2 together
    sw = 4'b1110;
    wait_edges(20);
    check("t4_level_a", int'(db_level), 14);
    sw = 4'b1111;
    wait_edges(20);
    check("t4_level_b", int'(db_level), 15);
    snap();
    sw = 4'b1010;
    t0 = cyc;
    wait_edges(3);
    check("t4_first_busy", int'(busy), 1);
    check("t4_first_grant", int'(grant_id), 2);
    wait_edges(37);
    check("t4_cyc_ch2", tick_cyc[2], t0 + 18);
    check("t4_cyc_ch0", tick_cyc[0], t0 + 34);
    check("t4_cnt_ch0", tick_cnt[0] - base[0], 1);
    check("t4_cnt_ch2", tick_cnt[2] - base[2], 1);
    check("t4_level", int'(db_level), 10);

    // 5: reset in the middle of a dwell, then re-dwell
    do_reset();
    snap();
    reset = 1'b0;
    sw    = 4'b0100;
    wait_edges(11);
    check("t5_busy_pre", int'(busy), 1);
    check("t5_grant_pre", int'(grant_id), 2);
    reset = 1'b1;
    wait_edges(1);
    check("t5_busy_rst", int'(busy), 0);
    check("t5_level_rst", int'(db_level), 0);
    check("t5_tick_rst", int'(db_tick), 0);
    check("t5_grant_rst", int'(grant_id), 0);
    check("t5_no_tick", tick_cnt[2] - base[2], 0);
    reset = 1'b0;
    t1    = cyc;
    wait_edges(2);
    check("t5_busy_e1", int'(busy), 0);
    wait_edges(1);
    check("t5_busy_e2", int'(busy), 1);
    check("t5_grant_e2", int'(grant_id), 2);
    wait_edges(17);
    check("t5_redwell_cyc", tick_cyc[2], t1 + 18);
    check("t5_redwell_level", int'(db_level), 4);

    // 6: short glitch on ch3 while ch1 holds the timer
    do_reset();
    snap();
    reset = 1'b0;
    sw    = 4'b0010;
    t0    = cyc;
    wait_edges(5);
    check("t6_busy", int'(busy), 1);
    check("t6_grant", int'(grant_id), 1);
    sw = 4'b1010;
    wait_edges(3);
    sw = 4'b0010;
    wait_edges(40);
    check("t6_g3", g3_cnt - g3base, 0);
    check("t6_tick3", tick_cnt[3] - base[3], 0);
    check("t6_tick1", tick_cnt[1] - base[1], 1);
    check("t6_cyc1", tick_cyc[1], t0 + 18);
    check("t6_level", int'(db_level), 2);

    check("onehot_ticks", multi_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
